ex_mem_latch: RTL

EX_MEM_LATCH -- requirements
Module: ex_mem_latch

---
 rtl/ex_mem_latch.sv | 84 ++++++++
 1 files changed

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: holds an outstanding data-memory request until dhit,
// turns flushed/invalid slots into bubbles, and freezes on halt. Optional stall counter under EX_MEM_STALL_CNT_EN.
module ex_mem_latch (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_npc,
  input  logic [4:0]  ex_reg_wr,
  input  logic        ex_reg_wen,
  input  logic        ex_dren,
  input  logic        ex_dwen,
  input  logic        ex_halt,
  output logic [31:0] mem_alu_out,
  output logic [31:0] mem_store_data,
  output logic [31:0] mem_npc,
  output logic [4:0]  reg_wr_mem,
  output logic        mem_reg_wen,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        mem_halt,
`ifdef EX_MEM_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        mem_busy
);

  logic advance;
  logic bubble;

  assign mem_busy = dmemREN | dmemWEN;
  // A halted stage never advances again, so every output stays frozen until reset.
  assign advance  = (dhit | (ihit & ~mem_busy)) & ~mem_halt;
  assign bubble   = flush | ~ex_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_alu_out    <= '0;
      mem_store_data <= '0;
      mem_npc        <= '0;
      reg_wr_mem     <= '0;
      mem_reg_wen    <= 1'b0;
      dmemREN        <= 1'b0;
      dmemWEN        <= 1'b0;
      mem_halt       <= 1'b0;
    end else if (advance) begin
      if (bubble) begin
        mem_alu_out    <= '0;
        mem_store_data <= '0;
        mem_npc        <= '0;
        reg_wr_mem     <= '0;
        mem_reg_wen    <= 1'b0;
        dmemREN        <= 1'b0;
        dmemWEN        <= 1'b0;
        mem_halt       <= 1'b0;
      end else begin
        mem_alu_out    <= ex_alu_out;
        mem_store_data <= ex_store_data;
        mem_npc        <= ex_npc;
        // Non-writing instructions expose register 0 so forwarding never matches them.
        reg_wr_mem     <= ex_reg_wen ? ex_reg_wr : 5'd0;
        mem_reg_wen    <= ex_reg_wen;
        dmemREN        <= ex_dren & ~ex_dwen;
        dmemWEN        <= ex_dwen;
        mem_halt       <= ex_halt;
      end
    end
  end

`ifdef EX_MEM_STALL_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (mem_busy && !dhit && !mem_halt && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
